// File: rtl/sa_pkg.sv
// ============================================================================
// Module : sa_pkg
// Brief  : Shared constants, FSM state encoding and width helper for sa_sched.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sa_pkg;

  localparam int c_DW     = 16;  // Q2.13 sample width
  localparam int c_FRAC   = 13;
  localparam int c_PE_LAT = 5;   // clocks per PE update (one beat)

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sa_state_e;

  // Counter width able to hold 0..n_max inclusive
  function automatic int nw_of(input int n_max);
    return $clog2(n_max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_skew_gen.sv
// ============================================================================
// Module : sa_skew_gen
// Brief  : Beat counter plus S-bit skew shift register producing lane valids.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sa_skew_gen #(
  parameter int S      = 64,
  parameter int PE_LAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_push,
  output logic         o_beat_start,
  output logic [S-1:0] o_lane_vld,
  output logic         o_empty
);

  localparam int CW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(PE_LAT - 1);

  logic [CW-1:0] r_cnt;
  logic [S-1:0]  r_sk;

  // Lane 0 takes the newest vector; each beat it moves one lane to the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sk  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sk  <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + CW'(1);
      if (r_cnt == '0) begin
        r_sk <= {r_sk[S-2:0], i_push};
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_beat_start = i_en && (r_cnt == '0);
  assign o_lane_vld   = r_sk;
  assign o_empty      = (r_sk == '0);

endmodule

`default_nettype wire

// File: rtl/sa_sched.sv
// ============================================================================
// Module : sa_sched
// Brief  : Job sequencer for the weight-stationary systolic array.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sa_sched
  import sa_pkg::*;
#(
  parameter int S      = 64,
  parameter int PE_LAT = c_PE_LAT,
  parameter int N_MAX  = 1024,
  parameter int NW     = nw_of(N_MAX),
  parameter int RW     = $clog2(S)
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_START,
  input  logic [NW-1:0] I_CFG_N,
  output logic          O_BUSY,
  output logic          O_DONE,
  output logic          O_W_REQ,
  output logic [RW-1:0] O_W_ROW,
  input  logic          I_W_RVLD,
  output logic [S-1:0]  O_SA_W_VLD,
  input  logic          I_XSRC_VLD,
  output logic          O_XSRC_RDY,
  output logic [S-1:0]  O_SA_X_VLD,
  input  logic [S-1:0]  I_SA_OUT_VLD,
  output logic [NW-1:0] O_OUT_CNT
);

  sa_state_e     r_state;
  sa_state_e     w_next;
  logic [NW-1:0] r_n;
  logic [RW-1:0] r_row;
  logic [NW-1:0] r_fed;
  logic [NW-1:0] r_out_cnt;

  logic          w_start_ok;
  logic          w_en;
  logic          w_beat_start;
  logic          w_push;
  logic          w_row_last;
  logic          w_collect;
  logic          w_empty;
  logic [S-1:0]  w_lane_vld;
  logic          w_unused_out_vld;

  // Only the bottom-right lane marks a finished result; other lanes are informational.
  assign w_unused_out_vld = ^I_SA_OUT_VLD[S-2:0];

  assign w_start_ok = (r_state == IDLE) && I_START;
  assign w_en       = (r_state == FEED) || (r_state == DRAIN);
  assign w_row_last = (r_row == RW'(S - 1));
  assign w_push     = (r_state == FEED) && w_beat_start && (r_fed < r_n) && I_XSRC_VLD;
  assign w_collect  = w_en && I_SA_OUT_VLD[S-1] && (r_out_cnt < r_n);

  sa_skew_gen #(
    .S      (S),
    .PE_LAT (PE_LAT)
  ) u_skew (
    .clk          (I_CLK),
    .rst_n        (I_RST_N),
    .i_clr        (w_start_ok),
    .i_en         (w_en),
    .i_push       (w_push),
    .o_beat_start (w_beat_start),
    .o_lane_vld   (w_lane_vld),
    .o_empty      (w_empty)
  );

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (I_START) w_next = LOAD_W;
      LOAD_W:  if (I_W_RVLD && w_row_last) w_next = (r_n == '0) ? DONE : FEED;
      FEED:    if (r_fed == r_n) w_next = DRAIN;
      DRAIN:   if (w_empty && (r_out_cnt == r_n)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Job counters; they keep their final values until the next accepted start.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_n       <= '0;
      r_row     <= '0;
      r_fed     <= '0;
      r_out_cnt <= '0;
    end else if (w_start_ok) begin
      r_n       <= I_CFG_N;
      r_row     <= '0;
      r_fed     <= '0;
      r_out_cnt <= '0;
    end else begin
      if ((r_state == LOAD_W) && I_W_RVLD) begin
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end
      if (w_push) begin
        r_fed <= r_fed + NW'(1);
      end
      if (w_collect) begin
        r_out_cnt <= r_out_cnt + NW'(1);
      end
    end
  end

  always_comb begin
    O_BUSY     = (r_state == LOAD_W) || w_en;
    O_DONE     = (r_state == DONE);
    O_W_REQ    = (r_state == LOAD_W);
    O_W_ROW    = (r_state == LOAD_W) ? r_row : '0;
    O_SA_W_VLD = ((r_state == LOAD_W) && I_W_RVLD) ? (S'(1) << r_row) : '0;
    O_XSRC_RDY = w_push;
    O_SA_X_VLD = w_lane_vld;
    O_OUT_CNT  = r_out_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_sa_sched.sv
// ============================================================================
// Module : tb_sa_sched
// Brief  : Directed self-checking bench for sa_sched (S=4, PE_LAT=5).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sa_sched;

  localparam int S      = 4;
  localparam int PE_LAT = 5;
  localparam int N_MAX  = 1024;
  localparam int NW     = 11;
  localparam int RW     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] cfg_n;
  logic          busy, done, w_req, w_rvld, xsrc_vld, xsrc_rdy;
  logic [RW-1:0] w_row;
  logic [S-1:0]  sa_w_vld, sa_x_vld, sa_out_vld;
  logic [NW-1:0] out_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected lane-valid pattern per beat: plain job, then job with a bubble at beat 1
  logic [3:0] exp_plain  [0:6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] exp_bubble [0:7] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};

  always #5 clk = ~clk;

  sa_sched #(
    .S      (S),
    .PE_LAT (PE_LAT),
    .N_MAX  (N_MAX)
  ) dut (
    .I_CLK        (clk),
    .I_RST_N      (rst_n),
    .I_START      (start),
    .I_CFG_N      (cfg_n),
    .O_BUSY       (busy),
    .O_DONE       (done),
    .O_W_REQ      (w_req),
    .O_W_ROW      (w_row),
    .I_W_RVLD     (w_rvld),
    .O_SA_W_VLD   (sa_w_vld),
    .I_XSRC_VLD   (xsrc_vld),
    .O_XSRC_RDY   (xsrc_rdy),
    .O_SA_X_VLD   (sa_x_vld),
    .I_SA_OUT_VLD (sa_out_vld),
    .O_OUT_CNT    (out_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, w_req, w_row, sa_w_vld, xsrc_rdy, sa_x_vld, out_cnt});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_n = '0; w_rvld = 1'b0;
    xsrc_vld = 1'b0; sa_out_vld = '0;
    tick(); tick();
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_outputs", all_outs(), 64'd0);

    // Job 1: N=3, weights back-to-back, activations always ready
    start = 1'b1; cfg_n = 11'd3; w_rvld = 1'b1; xsrc_vld = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < S; r++) begin
      #1;
      check("j1_busy_load", busy, 1);
      check("j1_w_req", w_req, 1);
      check("j1_w_row", w_row, r);
      check("j1_sa_w_vld", sa_w_vld, 64'(1) << r);
      tick();
    end
    for (int c = 0; c < 35; c++) begin
      start      = (c == 2);
      cfg_n      = (c == 2) ? 11'd7 : 11'd3;
      sa_out_vld = (c >= 20 && c <= 24) ? 4'b1000 : 4'b0000;
      #1;
      if (c % 5 == 3) check($sformatf("j1_lanes_b%0d", c / 5), sa_x_vld, exp_plain[c / 5]);
      check($sformatf("j1_rdy_c%0d", c), xsrc_rdy, (c == 0 || c == 5 || c == 10));
      check($sformatf("j1_done_c%0d", c), done, (c == 32));
      check($sformatf("j1_busy_c%0d", c), busy, (c < 32));
      if (c == 22) check("j1_cnt_mid", out_cnt, 2);
      tick();
    end
    sa_out_vld = '0;
    check("j1_cnt_saturated", out_cnt, 3);

    // Job 2: weight rows return 3 clocks late, activation missing at beat 1
    start = 1'b1; cfg_n = 11'd3; w_rvld = 1'b0;
    tick();
    start = 1'b0;
    for (int r = 0; r < S; r++) begin
      for (int k = 0; k < 3; k++) begin
        w_rvld = 1'b0;
        #1;
        check("j2_wait_req", w_req, 1);
        check("j2_wait_row", w_row, r);
        check("j2_wait_wvld", sa_w_vld, 0);
        tick();
      end
      w_rvld = 1'b1;
      #1;
      check("j2_sa_w_vld", sa_w_vld, 64'(1) << r);
      tick();
    end
    w_rvld = 1'b0;
    for (int c = 0; c < 39; c++) begin
      xsrc_vld   = !(c >= 5 && c < 10);
      sa_out_vld = (c == 18 || c == 25 || c == 30) ? 4'b1000 : 4'b0000;
      #1;
      if (c % 5 == 3) check($sformatf("j2_lanes_b%0d", c / 5), sa_x_vld, exp_bubble[c / 5]);
      check($sformatf("j2_rdy_c%0d", c), xsrc_rdy, (c == 0 || c == 10 || c == 15));
      check($sformatf("j2_done_c%0d", c), done, (c == 37));
      tick();
    end
    sa_out_vld = '0;
    check("j2_cnt_final", out_cnt, 3);

    // Job 3: asynchronous reset during FEED with one vector fed
    start = 1'b1; cfg_n = 11'd2; w_rvld = 1'b1; xsrc_vld = 1'b1;
    tick();
    start = 1'b0;
    repeat (S) tick();
    check("j3_first_rdy", xsrc_rdy, 1);
    tick(); tick();
    check("j3_busy_feed", busy, 1);
    check("j3_lane0", sa_x_vld, 4'b0001);
    #2 rst_n = 1'b0;
    #1 check("j3_async_reset", all_outs(), 64'd0);
    tick();
    check("j3_reset_held", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();

    // Job 4: zero vectors still loads every weight row
    start = 1'b1; cfg_n = 11'd0; w_rvld = 1'b1; xsrc_vld = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < S; r++) begin
      #1;
      check("j4_sa_w_vld", sa_w_vld, 64'(1) << r);
      check("j4_no_rdy", xsrc_rdy, 0);
      tick();
    end
    check("j4_done", done, 1);
    check("j4_busy", busy, 0);
    check("j4_cnt", out_cnt, 0);
    check("j4_rdy", xsrc_rdy, 0);
    tick();
    check("j4_done_pulse", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
